// File: rtl/cordic_pkg.sv
// cordic_pkg: shared Q16.16 constants, quadrant codes, FSM states and atan table for the CORDIC chain
package cordic_pkg;
  localparam logic [31:0] K      = 32'd39797;
  localparam logic [31:0] PI_4   = 32'd51472;
  localparam logic [31:0] PI_2   = 32'd102944;
  localparam logic [31:0] PI     = 32'd205887;
  localparam logic [31:0] TWO_PI = 32'd411775;
  localparam logic [2:0] Q_0    = 3'd0;
  localparam logic [2:0] Q_90   = 3'd1;
  localparam logic [2:0] Q_180  = 3'd2;
  localparam logic [2:0] Q_180B = 3'd3;
  localparam logic [2:0] Q_270  = 3'd4;
  typedef enum logic [1:0] {IDLE, ITERA, CORRIGE} state_t;
  localparam logic [31:0] ATAN_TAB [16] = '{
    32'd51472, 32'd30386, 32'd16055, 32'd8150, 32'd4091, 32'd2047, 32'd1024, 32'd512,
    32'd256,   32'd128,   32'd64,    32'd32,   32'd16,   32'd8,    32'd4,    32'd2
  };
endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational atan(2^-i_idx) in Q16.16; i_idx 4-bit index, o_atan WIDTH-bit value
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_idx,
  output logic [WIDTH-1:0] o_atan
);
  assign o_atan = WIDTH'(ATAN_TAB[i_idx]);
endmodule

// File: rtl/cordic_rotacao.sv
// cordic_rotacao: iterative rotation CORDIC with quadrant unmapping; enable/z_in/quadrante in, cos_out/sin_out/busy/done out
module cordic_rotacao
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] z_in,
  input  logic [2:0]       quadrante,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out,
  output logic             busy,
  output logic             done
);
  state_t r_state, w_next;
  logic signed [WIDTH-1:0] r_x, r_y, r_z;
  logic [3:0] r_i;
  logic [2:0] r_quad;
  logic signed [WIDTH-1:0] w_atan, w_xs, w_ys, w_cos, w_sin;
  logic w_pos;

  cordic_atan_lut #(.WIDTH(WIDTH)) u_lut (.i_idx(r_i), .o_atan(w_atan));

  assign busy  = (r_state != IDLE);
  assign w_pos = ~r_z[WIDTH-1];
  assign w_xs  = r_x >>> r_i;
  assign w_ys  = r_y >>> r_i;

  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (enable ? ITERA : IDLE) :
             (r_state == ITERA) ? ((r_i == 4'(ITER-1)) ? CORRIGE : ITERA) : IDLE;
  end

  always_comb begin
    w_cos = r_x;
    w_sin = r_y;
    w_cos = (r_quad == Q_90)                        ? -r_y :
            (r_quad == Q_180 || r_quad == Q_180B)   ? -r_x :
            (r_quad == Q_270)                       ?  r_y : r_x;
    w_sin = (r_quad == Q_90)                        ?  r_x :
            (r_quad == Q_180 || r_quad == Q_180B)   ? -r_y :
            (r_quad == Q_270)                       ? -r_x : r_y;
  end

  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_i     <= '0;
      r_quad  <= '0;
      cos_out <= '0;
      sin_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE && enable) begin
        r_x    <= WIDTH'(K);
        r_y    <= '0;
        r_z    <= z_in;
        r_quad <= quadrante;
        r_i    <= '0;
      end
      if (r_state == ITERA) begin
        r_x <= w_pos ? r_x - w_ys : r_x + w_ys;
        r_y <= w_pos ? r_y + w_xs : r_y - w_xs;
        r_z <= w_pos ? r_z - w_atan : r_z + w_atan;
        r_i <= r_i + 4'd1;
      end
      if (r_state == CORRIGE) begin
        cos_out <= w_cos;
        sin_out <= w_sin;
        done    <= 1'b1;
      end
    end
  end
endmodule

// File: doc/cordic_rotacao.md
# cordic_rotacao

Iterative rotation-mode CORDIC stage. It sits directly downstream of the π/4 quadrant-correction stage and consumes that stage's reduced angle and 3-bit quadrant code. It computes cos/sin of the reduced angle in Q16.16 over ITER shift-add iterations. It then applies the inverse quadrant mapping so that the outputs are cos/sin of the original angle.

## Interface
- WIDTH, 32: data width of angle and results, signed Q16.16 (1.0 = 65536).
- ITER, 16: number of CORDIC iterations (1..16; the atan table holds 16 entries).
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  start request; sampled only in IDLE.
- z_in  input  WIDTH  signed reduced angle in radians, expected range [-51472, +51472].
- quadrante  input  3  quadrant code from upstream: 0 none, 1 +90°, 2/3 +180°, 4 +270°.
- cos_out  output  WIDTH  signed cos of original angle, registered.
- sin_out  output  WIDTH  signed sin of original angle, registered.
- busy  output  1  high from the accept edge until the edge that asserts done.
- done  output  1  one-cycle pulse; cos_out/sin_out are valid from this cycle until the next done.

## Operation
- States: IDLE, ITERA, CORRIGE.
- IDLE, enable=1:
  - latch x←K=39797 (0.60725), y←0, z←z_in, quad←quadrante, i←0.
  - busy←1, go to ITERA.
- IDLE, enable=0: hold.
- ITERA, per edge:
  - d=+1 if z≥0, else -1.
  - x←x−d·(y>>>i), y←y+d·(x>>>i), z←z−d·atan[i]. All updates use old values and arithmetic shifts, and are WIDTH-bit wrapping (no overflow occurs in range).
  - i←i+1. When i==ITER−1, go to CORRIGE.
- atan[i] = round(atan(2^-i)·65536): 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
- CORRIGE: register outputs by quad, then done←1, busy←0, go to IDLE.
  - quad 0: cos=x, sin=y.
  - quad 1: cos=−y, sin=x.
  - quad 2 or 3: cos=−x, sin=−y.
  - quad 4: cos=y, sin=−x.
  - quad 5–7 (invalid): treated as 0.
- done is cleared on the following edge. Outputs hold until the next CORRIGE.
- enable while busy: ignored, no queuing.
- enable on the same edge that done is high: IDLE is already re-entered, so a new operation is accepted.
- Negation is two's complement. −(−2^(WIDTH−1)) cannot occur in range.

## Timing
- Reset values: cos_out=0, sin_out=0, done=0, busy=0, state=IDLE, internal x/y/z/i/quad=0.
- Reset mid-operation aborts with no done pulse. The first enable after rst deasserts is accepted normally.
- Accept edge E0; iterations on E1..E_ITER; CORRIGE on E_(ITER+1).
- done is high in the cycle after E_(ITER+1); latency is ITER+1 edges (17 at default).
- Throughput: one result per ITER+2 cycles when enable is held high (done cycle doubles as IDLE accept).
- z_in and quadrante are sampled only at E0; later changes have no effect.

## Structure
- Shared package cordic_pkg holds:
  - Q16.16 constants K=39797 and π/4, π/2, π, 2π (51472, 102944, 205887, 411775), also used by the upstream stage.
  - quadrant code localparams.
  - state encodings IDLE/ITERA/CORRIGE.
- One sub-module: cordic_atan_lut, a combinational 4-bit index → WIDTH-bit atan value (table above).
- Datapath and FSM live in cordic_rotacao.

## Test plan
Tolerance is ±8 LSB on every result.
- z_in=0, quad 0 → cos≈65536, sin≈0; done exactly 17 cycles after the accept edge, width 1 cycle.
- z_in=51472, quad 0 → cos≈46341, sin≈46341. z_in=−51472, quad 0 → cos≈46341, sin≈−46341.
- z_in=0 with each quad:
  - quad 1 → (≈0, ≈65536).
  - quad 2 and 3 → (≈−65536, ≈0).
  - quad 4 → (≈0, ≈−65536).
  - quad 6 → (≈65536, ≈0).
- Reset and enable handling:
  - rst pulsed at iteration 8 → no done; outputs 0, busy 0 next cycle.
  - a following enable with z_in=0 completes normally.
- Busy and back-to-back behaviour:
  - enable re-asserted with z_in=25736 while busy → ignored; result matches the first operation only.
  - enable held high → done pulses every 18 cycles.
